// File: rtl/mm_stream_feeder.sv
// Memory-to-stream feeder for the MM matrix multiplier: reads A then B row-major from a
// sync-read memory and presents them as an in_valid/busy stream with column/row-end flags.
module mm_stream_feeder #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [3:0]    m1_rows,
    input  logic [3:0]    m1_cols,
    input  logic [3:0]    m2_rows,
    input  logic [3:0]    m2_cols,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    input  logic          busy,
    output logic [7:0]    in_data,
    output logic          in_valid,
    output logic          col_end,
    output logic          row_end,
    output logic          feed_busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StFetch, StStream, StFin} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [3:0]    c1_q, c1_d, c2_q, c2_d;
    logic [7:0]    na_q, na_d;
    logic [8:0]    n_q, n_d;
    logic [8:0]    rd_cnt_q, rd_cnt_d;
    logic [8:0]    ld_cnt_q, ld_cnt_d;
    logic [3:0]    col_q, col_d;
    logic          data_vld_q, data_vld_d;
    logic          skid_valid_q, skid_valid_d;
    logic [7:0]    skid_data_q, skid_data_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          col_end_q, col_end_d;
    logic          row_end_q, row_end_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic       dims_zero, consume, slot_free, load_out, can_issue;
    logic       in_b, ld_col_end, ld_a_last, ld_last;
    logic [3:0] cur_cols;
    logic [7:0] load_data;

    assign dims_zero = (m1_rows == 4'd0) | (m1_cols == 4'd0) |
                       (m2_rows == 4'd0) | (m2_cols == 4'd0);
    assign consume   = out_valid_q & ~busy;
    assign slot_free = ~out_valid_q | consume;
    assign load_out  = slot_free & (skid_valid_q | data_vld_q);
    assign load_data = skid_valid_q ? skid_data_q : mem_rdata;

    // Flags are derived for the element entering the output register, indexed by ld_cnt_q.
    assign in_b       = ld_cnt_q >= {1'b0, na_q};
    assign cur_cols   = in_b ? c2_q : c1_q;
    assign ld_col_end = col_q == (cur_cols - 4'd1);
    assign ld_a_last  = (ld_cnt_q + 9'd1) == {1'b0, na_q};
    assign ld_last    = (ld_cnt_q + 9'd1) == n_q;

    // A read is safe only if its data is guaranteed a slot (output or skid) on return.
    assign can_issue = (rd_cnt_q < n_q) & ~skid_valid_q & ~(out_valid_q & data_vld_q & busy);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        na_d         = na_q;
        n_d          = n_q;
        rd_cnt_d     = rd_cnt_q;
        ld_cnt_d     = ld_cnt_q;
        col_d        = col_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        col_end_d    = col_end_q;
        row_end_d    = row_end_q;
        last_d       = last_q;
        err_d        = 1'b0;
        mem_rd       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dims_zero) begin
                        err_d = 1'b1;
                    end else begin
                        base_d       = base_addr;
                        c1_d         = m1_cols;
                        c2_d         = m2_cols;
                        na_d         = 8'(m1_rows) * 8'(m1_cols);
                        n_d          = 9'(8'(m1_rows) * 8'(m1_cols)) +
                                       9'(8'(m2_rows) * 8'(m2_cols));
                        rd_cnt_d     = 9'd0;
                        ld_cnt_d     = 9'd0;
                        col_d        = 4'd0;
                        skid_valid_d = 1'b0;
                        out_valid_d  = 1'b0;
                        col_end_d    = 1'b0;
                        row_end_d    = 1'b0;
                        last_d       = 1'b0;
                        state_d      = StFetch;
                    end
                end
            end
            StFetch: begin
                mem_rd  = 1'b1;
                state_d = StStream;
            end
            StStream: begin
                mem_rd = can_issue;
                if (slot_free) begin
                    if (load_out) begin
                        out_data_d  = load_data;
                        out_valid_d = 1'b1;
                        col_end_d   = ld_col_end;
                        row_end_d   = ld_a_last | ld_last;
                        last_d      = ld_last;
                        ld_cnt_d    = ld_cnt_q + 9'd1;
                        col_d       = (ld_col_end | ld_a_last) ? 4'd0 : col_q + 4'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        col_end_d   = 1'b0;
                        row_end_d   = 1'b0;
                        last_d      = 1'b0;
                    end
                    // Skid drains into the output; any returning word backfills it.
                    skid_valid_d = skid_valid_q & data_vld_q;
                    if (skid_valid_q & data_vld_q) skid_data_d = mem_rdata;
                end else if (data_vld_q) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = mem_rdata;
                end
                if (consume & last_q) state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (mem_rd) rd_cnt_d = rd_cnt_q + 9'd1;
        data_vld_d = mem_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            c1_q         <= 4'd0;
            c2_q         <= 4'd0;
            na_q         <= 8'd0;
            n_q          <= 9'd0;
            rd_cnt_q     <= 9'd0;
            ld_cnt_q     <= 9'd0;
            col_q        <= 4'd0;
            data_vld_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 8'd0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            col_end_q    <= 1'b0;
            row_end_q    <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            na_q         <= na_d;
            n_q          <= n_d;
            rd_cnt_q     <= rd_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            col_q        <= col_d;
            data_vld_q   <= data_vld_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            col_end_q    <= col_end_d;
            row_end_q    <= row_end_d;
            last_q       <= last_d;
            err_q        <= err_d;
        end
    end

    // Address wraps modulo 2^AW by truncation.
    assign mem_addr  = base_q + AW'(rd_cnt_q);
    assign in_data   = out_data_q;
    assign in_valid  = out_valid_q;
    assign col_end   = col_end_q;
    assign row_end   = row_end_q;
    assign feed_busy = state_q != StIdle;
    assign done      = state_q == StFin;
    assign err       = err_q;

endmodule

// File: tb/tb_mm_stream_feeder.sv
// Randomised bench for mm_stream_feeder: a memory model feeds the DUT and every consumed
// element is compared against a row-major walk of A then B computed from the job shape.
module tb_mm_stream_feeder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [3:0] m1_rows, m1_cols, m2_rows, m2_cols;
    logic       mem_rd;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       busy;
    logic [7:0] in_data;
    logic       in_valid, col_end, row_end, feed_busy, done, err;

    logic [7:0] mem [0:1023];

    int vectors = 0;
    int errors  = 0;

    mm_stream_feeder #(.AW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .m1_rows   (m1_rows),
        .m1_cols   (m1_cols),
        .m2_rows   (m2_rows),
        .m2_cols   (m2_cols),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .col_end   (col_end),
        .row_end   (row_end),
        .feed_busy (feed_busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one job; stall_k >= 0 forces busy for 3 cycles while element stall_k is presented.
    task automatic run_job(input logic [9:0] b, input logic [3:0] r1, input logic [3:0] c1,
                           input logic [3:0] r2, input logic [3:0] c2, input int pct,
                           input int stall_k);
        logic [7:0] ed[$];
        logic       ec[$];
        logic       er[$];
        int         n, k, idx, cyc, rd_count, stall_cnt, held_cycles;
        logic       held;
        logic [7:0] held_data;

        k = 0;
        for (int i = 0; i < int'(r1); i++)
            for (int j = 0; j < int'(c1); j++) begin
                ed.push_back(mem[(int'(b) + k) % 1024]);
                ec.push_back(j == int'(c1) - 1);
                er.push_back(i == int'(r1) - 1 && j == int'(c1) - 1);
                k++;
            end
        for (int i = 0; i < int'(r2); i++)
            for (int j = 0; j < int'(c2); j++) begin
                ed.push_back(mem[(int'(b) + k) % 1024]);
                ec.push_back(j == int'(c2) - 1);
                er.push_back(i == int'(r2) - 1 && j == int'(c2) - 1);
                k++;
            end
        n = ed.size();

        @(posedge clk); #1;
        base_addr = b; m1_rows = r1; m1_cols = c1; m2_rows = r2; m2_cols = c2;
        start = 1'b1; busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        @(negedge clk);
        check("fetch_rd", mem_rd, 1);
        check("fetch_addr", mem_addr, b);
        check("fetch_valid", in_valid, 0);
        check("fetch_busy", feed_busy, 1);
        rd_count = int'(mem_rd);
        @(negedge clk);
        check("lat_valid_c1", in_valid, 0);
        rd_count += int'(mem_rd);

        idx = 0; cyc = 0; held = 1'b0; held_data = 8'd0; held_cycles = 0;
        stall_cnt = (stall_k >= 0) ? 3 : 0;
        while (idx < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            rd_count += int'(mem_rd);
            if (cyc == 1) check("lat_elem0", in_valid, 1);
            if (in_valid) begin
                if (held) check("hold_data", in_data, held_data);
                if (!busy) begin
                    check($sformatf("data[%0d]", idx), in_data, ed[idx]);
                    check($sformatf("col_end[%0d]", idx), col_end, ec[idx]);
                    check($sformatf("row_end[%0d]", idx), row_end, er[idx]);
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = in_data;
                    held_cycles++;
                end
            end
            if (idx < n) begin
                @(posedge clk); #1;
                if (idx == stall_k && stall_cnt > 0) begin
                    busy = 1'b1;
                    stall_cnt--;
                end else begin
                    busy = ($urandom_range(0, 99) < pct);
                end
            end
        end
        check("elements_consumed", idx, n);
        busy = 1'b0;

        @(negedge clk);
        rd_count += int'(mem_rd);
        check("done_pulse", done, 1);
        check("fin_valid", in_valid, 0);
        check("fin_flags", {col_end, row_end}, 0);
        @(negedge clk);
        check("done_low", done, 0);
        check("idle_busy", feed_busy, 0);
        check("rd_count", rd_count, n);
        if (stall_k >= 0) check("stall_cycles", held_cycles, 3);
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b0; start = 1'b0; busy = 1'b0; base_addr = 10'd0;
        m1_rows = 4'd0; m1_cols = 4'd0; m2_rows = 4'd0; m2_cols = 4'd0;
        mem_rdata = 8'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        #3;
        check("rst_outs", {in_data, in_valid, col_end, row_end, feed_busy, done, err, mem_rd}, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Basic 2x3 by 3x2 job on values 1..12.
        for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);
        run_job(10'd0, 4'd2, 4'd3, 4'd3, 4'd2, 0, -1);
        // Same job, element index 4 held for 3 cycles.
        run_job(10'd0, 4'd2, 4'd3, 4'd3, 4'd2, 0, 4);

        // 1x1 by 1x1.
        mem[100] = 8'd7; mem[101] = 8'd9;
        run_job(10'd100, 4'd1, 4'd1, 4'd1, 4'd1, 0, -1);

        // Zero dimension is rejected.
        @(posedge clk); #1;
        m1_rows = 4'd2; m1_cols = 4'd0; m2_rows = 4'd3; m2_cols = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_no_rd", mem_rd, 0);
        check("err_idle", feed_busy, 0);
        @(negedge clk);
        check("err_low", err, 0);
        check("err_no_rd2", mem_rd, 0);
        check("err_idle2", feed_busy, 0);

        // Largest job, address wraps 1023 -> 0, with random stalls.
        run_job(10'd1000, 4'd15, 4'd15, 4'd15, 4'd15, 20, -1);

        // Random shapes, bases and stall density.
        for (int t = 0; t < 10; t++)
            run_job(10'($urandom), 4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)),
                    4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)),
                    int'($urandom_range(0, 60)), -1);

        // Reset in the middle of a stream, then a clean rerun.
        @(posedge clk); #1;
        base_addr = 10'd0; m1_rows = 4'd2; m1_cols = 4'd3; m2_rows = 4'd3; m2_cols = 4'd2;
        start = 1'b1; busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cnt = 0;
        while (!in_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("mid_started", in_valid, 1);
        repeat (3) @(negedge clk);
        check("mid_k3", in_data, 8'd4);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_outs", {in_data, in_valid, col_end, row_end, feed_busy, done, err, mem_rd},
              0);
        check("mid_rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_quiet", {done, err, feed_busy}, 0);
        run_job(10'd0, 4'd2, 4'd3, 4'd3, 4'd2, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
